// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register indices, ExcCodes, and field positions.
// Cause layout helper used by the read path.
package cp0_pkg;

  localparam logic [4:0] COUNT_IDX   = 5'd9;
  localparam logic [4:0] COMPARE_IDX = 5'd11;
  localparam logic [4:0] STATUS_IDX  = 5'd12;
  localparam logic [4:0] CAUSE_IDX   = 5'd13;
  localparam logic [4:0] EPC_IDX     = 5'd14;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_BREAK   = 5'd9;
  localparam logic [4:0] EXC_TEQ     = 5'd13;

  localparam int IE_BIT      = 0;
  localparam int IM_LSB      = 8;
  localparam int IM_MSB      = 15;
  localparam int IP_LSB      = 8;
  localparam int IP_MSB      = 15;
  localparam int EXCCODE_LSB = 2;
  localparam int EXCCODE_MSB = 6;
  localparam int TI_BIT      = 30;

  function automatic logic [31:0] pack_cause(input logic ti, input logic [7:0] ip,
                                             input logic [4:0] exccode);
    logic [31:0] c;
    c = '0;
    c[TI_BIT] = ti;
    c[IP_MSB:IP_LSB] = ip;
    c[EXCCODE_MSB:EXCCODE_LSB] = exccode;
    return c;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with sticky TI flag; only instantiated when
// CP0_CTRL_TIMER_EN is defined.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  always_comb begin
    count_d   = wr_count ? wdata : count_q + 32'd1;
    compare_d = wr_compare ? wdata : compare_q;
    // Writing Compare acknowledges the timer and beats a same-cycle match.
    if (wr_compare)
      ti_d = 1'b0;
    else
      ti_d = ti_q | ((count_q == compare_q) && (compare_q != 32'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor-0: Status/Cause/EPC, exception entry and ERET, interrupt latching.
// Optional Count/Compare timer is enabled by defining CP0_CTRL_TIMER_EN.
import cp0_pkg::*;

module cp0_ctrl #(
  parameter int          NUM_IRQ      = 6,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0004,
  parameter logic [31:0] STATUS_RST   = 32'h0000_0000,
  parameter int          STATUS_SHIFT = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mfc0,
  input  logic               mtc0,
  input  logic [31:0]        pc,
  input  logic [4:0]         Rd,
  input  logic [31:0]        wdata,
  input  logic               exception,
  input  logic               eret,
  input  logic [4:0]         cause,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [31:0]        rdata,
  output logic [31:0]        status,
  output logic [31:0]        exc_addr,
  output logic               irq_req
);

  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [7:0]  ip_q, ip_d;
  logic        mtc0_en;
  logic        ti;
  logic [7:0]  ip_eff;
  logic [31:0] cause_val;

  // Exception and ERET both swallow a same-cycle MTC0.
  assign mtc0_en = mtc0 & ~exception & ~eret;

`ifdef CP0_CTRL_TIMER_EN
  logic [31:0] count, compare;

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .wr_count   (mtc0_en && (Rd == COUNT_IDX)),
    .wr_compare (mtc0_en && (Rd == COMPARE_IDX)),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );
`else
  assign ti = 1'b0;
`endif

  always_comb begin
    ip_d = '0;
    ip_d[NUM_IRQ+1:2] = irq;
  end

  always_comb begin
    status_d  = status_q;
    epc_d     = epc_q;
    exccode_d = exccode_q;
    if (exception) begin
      status_d  = status_q << STATUS_SHIFT;
      epc_d     = pc;
      exccode_d = cause;
    end else if (eret) begin
      status_d = status_q >> STATUS_SHIFT;
    end else if (mtc0) begin
      case (Rd)
        STATUS_IDX: status_d  = wdata;
        CAUSE_IDX:  exccode_d = wdata[EXCCODE_MSB:EXCCODE_LSB];
        EPC_IDX:    epc_d     = wdata;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q  <= STATUS_RST;
      epc_q     <= '0;
      exccode_q <= '0;
      ip_q      <= '0;
    end else begin
      status_q  <= status_d;
      epc_q     <= epc_d;
      exccode_q <= exccode_d;
      ip_q      <= ip_d;
    end
  end

  assign ip_eff    = ip_q | {ti, 7'b0};
  assign cause_val = pack_cause(ti, ip_eff, exccode_q);

  always_comb begin
    rdata = '0;
    if (mfc0) begin
      case (Rd)
        STATUS_IDX:  rdata = status_q;
        CAUSE_IDX:   rdata = cause_val;
        EPC_IDX:     rdata = epc_q;
`ifdef CP0_CTRL_TIMER_EN
        COUNT_IDX:   rdata = count;
        COMPARE_IDX: rdata = compare;
`endif
        default:     rdata = '0;
      endcase
    end
  end

  assign status   = status_q;
  assign irq_req  = status_q[IE_BIT] & |(ip_eff & status_q[IM_MSB:IM_LSB]);
  assign exc_addr = (eret && !exception) ? epc_q : EXC_VECTOR;

endmodule
